// File: rtl/fracnet_t_sdiv_seq_pkg.sv
// Shared FracNet definitions for the sequential signed divider:
// FSM state encoding, quotient saturation limits and counter width.
package fracnet_t_sdiv_seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } div_state_t;

   localparam int QMAX   = 32767;
   localparam int QMIN   = -32768;
   localparam int DIN0_W = 26;
   localparam int CNT_W  = $clog2(DIN0_W);

endpackage

// File: rtl/fracnet_t_sdiv_seq.sv
// Sequential restoring signed divider, 26b / 9b -> 16b saturated quotient.
// Ports: ap_clk/ap_rst, in_valid/in_ready + din0/din1 operands,
// out_valid/out_ready + dout/rem/ovf/div0 results.
module fracnet_t_sdiv_seq
   import fracnet_t_sdiv_seq_pkg::*;
#(
   parameter int din0_WIDTH = 26,
   parameter int din1_WIDTH = 9,
   parameter int dout_WIDTH = 16
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [din0_WIDTH-1:0] din0,
   input  logic signed [din1_WIDTH-1:0] din1,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [dout_WIDTH-1:0] dout,
   output logic signed [din1_WIDTH-1:0] rem,
   output logic                         ovf,
   output logic                         div0
);

   localparam int D0 = din0_WIDTH;
   localparam int D1 = din1_WIDTH;
   localparam int DQ = dout_WIDTH;

   localparam logic [DQ-1:0] QMAX_V = DQ'(QMAX);
   localparam logic [DQ-1:0] QMIN_V = DQ'(QMIN);
   localparam logic [D0-1:0] LIM_P  = D0'(QMAX);
   localparam logic [D0-1:0] LIM_N  = D0'(-QMIN);

   div_state_t r_state;
   div_state_t w_state_nxt;

   logic [D1:0]      r_prem;
   logic [D0-1:0]    r_quo;
   logic [D1:0]      r_dvs;
   logic             r_s0;
   logic             r_s1;
   logic             r_zero;
   logic [CNT_W-1:0] r_cnt;

   logic [DQ-1:0]    r_dout;
   logic [D1-1:0]    r_rem;
   logic             r_ovf;
   logic             r_div0;

   logic             w_accept;
   logic [D0-1:0]    w_d0_abs;
   logic [D1:0]      w_d1_ext;
   logic [D1:0]      w_d1_abs;
   logic [D1+1:0]    w_shift;
   logic             w_ge;
   logic [D1:0]      w_diff;
   logic             w_qs;
   logic [D1-1:0]    w_remm;
   logic [DQ-1:0]    w_dout_fix;
   logic [D1-1:0]    w_rem_fix;
   logic             w_ovf_fix;

   assign in_ready  = (r_state == S_IDLE) & ~ap_rst;
   assign out_valid = (r_state == S_DONE);
   assign dout      = r_dout;
   assign rem       = r_rem;
   assign ovf       = r_ovf;
   assign div0      = r_div0;

   assign w_accept = in_valid & in_ready;

   // Magnitudes: unsigned D0 bits holds 2^(D0-1); the extra divisor
   // bit lets -2^(D1-1) become a positive magnitude.
   assign w_d0_abs = din0[D0-1] ? D0'(-din0) : D0'(din0);
   assign w_d1_ext = {din1[D1-1], din1};
   assign w_d1_abs = din1[D1-1] ? -w_d1_ext : w_d1_ext;

   // Restoring step: partial remainder shifted with the next dividend MSB.
   assign w_shift = {r_prem, r_quo[D0-1]};
   assign w_ge    = w_shift[D1+1] | (w_shift[D1:0] >= r_dvs);
   assign w_diff  = w_shift[D1:0] - r_dvs;

   assign w_qs   = r_s0 ^ r_s1;
   assign w_remm = r_prem[D1-1:0];

   always_comb begin
      w_ovf_fix  = 1'b0;
      w_dout_fix = r_quo[DQ-1:0];
      w_rem_fix  = r_s0 ? -w_remm : w_remm;
      if (r_zero) begin
         w_dout_fix = r_s0 ? QMIN_V : QMAX_V;
         w_rem_fix  = '0;
      end else if (w_qs) begin
         if (r_quo > LIM_N) begin
            w_ovf_fix  = 1'b1;
            w_dout_fix = QMIN_V;
         end else begin
            w_dout_fix = -r_quo[DQ-1:0];
         end
      end else if (r_quo > LIM_P) begin
         w_ovf_fix  = 1'b1;
         w_dout_fix = QMAX_V;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = S_CALC;
         S_CALC: if (r_cnt == '0) w_state_nxt = S_FIX;
         S_FIX:  w_state_nxt = S_DONE;
         S_DONE: if (out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_prem <= '0;
         r_quo  <= '0;
         r_dvs  <= '0;
         r_s0   <= 1'b0;
         r_s1   <= 1'b0;
         r_zero <= 1'b0;
         r_cnt  <= '0;
         r_dout <= '0;
         r_rem  <= '0;
         r_ovf  <= 1'b0;
         r_div0 <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_prem <= '0;
                  r_quo  <= w_d0_abs;
                  r_dvs  <= w_d1_abs;
                  r_s0   <= din0[D0-1];
                  r_s1   <= din1[D1-1];
                  r_zero <= (din1 == '0);
                  r_cnt  <= CNT_W'(D0 - 1);
               end
            end
            S_CALC: begin
               r_prem <= w_ge ? w_diff : w_shift[D1:0];
               r_quo  <= {r_quo[D0-2:0], w_ge};
               if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            end
            S_FIX: begin
               r_dout <= w_dout_fix;
               r_rem  <= w_rem_fix;
               r_ovf  <= w_ovf_fix;
               r_div0 <= r_zero;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fracnet_t_sdiv_seq.sv
// Bench for fracnet_t_sdiv_seq: directed and random divisions checked
// against an arithmetic reference, plus latency, backpressure and reset.
module tb_fracnet_t_sdiv_seq;

   logic               clk;
   logic               ap_rst;
   logic               in_valid;
   logic               in_ready;
   logic signed [25:0] din0;
   logic signed [8:0]  din1;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] dout;
   logic signed [8:0]  rem;
   logic               ovf;
   logic               div0;

   int n_chk;
   int n_fail;

   fracnet_t_sdiv_seq dut (
      .ap_clk    (clk),
      .ap_rst    (ap_rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .din0      (din0),
      .din1      (din1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout),
      .rem       (rem),
      .ovf       (ovf),
      .div0      (div0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model(input longint a, input longint b,
                        output longint q, output longint r,
                        output logic o, output logic z);
      o = 1'b0;
      z = 1'b0;
      if (b == 0) begin
         z = 1'b1;
         r = 0;
         q = (a >= 0) ? 32767 : -32768;
      end else begin
         q = a / b;
         r = a % b;
         if (q > 32767) begin
            q = 32767;
            o = 1'b1;
         end else if (q < -32768) begin
            q = -32768;
            o = 1'b1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic signed [25:0] a,
                         input logic signed [8:0]  b,
                         input int hold);
      longint eq, er;
      logic   eo, ez;
      int     w, lat;
      model(longint'(a), longint'(b), eq, er, eo, ez);
      w = 0;
      while (!in_ready && w < 60) begin
         tick();
         w++;
      end
      chk("in_ready_before_op", in_ready, 1);
      in_valid = 1'b1;
      din0 = a;
      din1 = b;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      chk("latency", lat, 27);
      chk("dout", dout, eq);
      chk("rem", rem, er);
      chk("ovf", ovf, eo);
      chk("div0", div0, ez);
      if (hold > 0) begin
         out_ready = 1'b0;
         for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            din0 = 26'($urandom);
            din1 = 9'($urandom);
            tick();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_dout", dout, eq);
            chk("bp_rem", rem, er);
            chk("bp_ovf", ovf, eo);
            chk("bp_div0", div0, ez);
         end
         in_valid = 1'b0;
         out_ready = 1'b1;
      end
      tick();
      chk("out_valid_drop", out_valid, 0);
      chk("in_ready_back", in_ready, 1);
   endtask

   initial begin
      logic signed [25:0] ra;
      logic signed [8:0]  rb;
      n_chk = 0;
      n_fail = 0;
      ap_rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      din0 = '0;
      din1 = '0;
      tick();
      tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dout", dout, 0);
      chk("rst_rem", rem, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_div0", div0, 0);
      ap_rst = 1'b0;
      #1;
      chk("idle_in_ready", in_ready, 1);

      run_op(26'sd1000, 9'sd10, 0);
      run_op(-26'sd1000, 9'sd7, 0);
      run_op(26'sd1000, -9'sd7, 0);
      run_op(26'sd33554431, 9'sd1, 0);
      run_op(-26'sd33554432, -9'sd1, 0);
      run_op(-26'sd33554432, -9'sd256, 0);
      run_op(-26'sd33554432, 9'sd255, 0);
      run_op(26'sd1234, 9'sd0, 0);
      run_op(-26'sd5, 9'sd0, 0);
      run_op(26'sd0, -9'sd3, 0);
      run_op(26'sd1000, -9'sd256, 10);
      run_op(26'sd99, 9'sd4, 0);

      // Abort an operation partway through CALC.
      in_valid = 1'b1;
      din0 = 26'sd7777;
      din1 = 9'sd5;
      tick();
      in_valid = 1'b0;
      repeat (11) tick();
      ap_rst = 1'b1;
      tick();
      ap_rst = 1'b0;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_dout", dout, 0);
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            tick();
         end
         chk("abort_no_result", seen, 0);
      end
      run_op(26'sd50, 9'sd3, 0);

      for (int i = 0; i < 30; i++) begin
         ra = 26'($urandom);
         ra = ra >>> $urandom_range(0, 25);
         rb = 9'($urandom);
         if ($urandom_range(0, 7) == 0) rb = '0;
         run_op(ra, rb, int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
